// File: rtl/spi_slave_os_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_os_if
// Description : SPI pins plus TX/RX stream handshakes for spi_slave_os.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_os_if #(
  parameter int WIDTH = 8
);
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             overrun;
  logic             underrun;
  logic             frame_err;
  logic             busy;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid,
           overrun, underrun, frame_err, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid, rx_ready,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid,
           overrun, underrun, frame_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_os.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_os
// Description : Oversampled SPI slave. sclk/cs_n/mosi are synchronised into
//               clk and treated as data. Supports all four SPI modes,
//               MSB/LSB-first order, multi-word frames and valid/ready
//               streaming with underrun/overrun/frame-error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_os #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_slave_os_if.slave bus
);

  localparam int                 c_cnt_w = $clog2(WIDTH);
  localparam logic               c_cpol  = (CPOL != 0);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_sclk_d;
  logic                   r_cs_n_d;
  logic                   r_armed;
  logic [c_cnt_w-1:0]     r_bit_cnt;
  logic                   r_sampled;
  logic [WIDTH-1:0]       r_shift_in;
  logic [WIDTH-1:0]       r_shift_out;
  logic [WIDTH-1:0]       r_rx_data;
  logic                   r_rx_valid;
  logic                   r_overrun;
  logic                   r_underrun;
  logic                   r_frame_err;

  logic                   w_sclk_s;
  logic                   w_cs_n_s;
  logic                   w_mosi_s;
  logic                   w_sync_ok;
  logic                   w_lead;
  logic                   w_trail;
  logic                   w_sample_edge;
  logic                   w_shift_edge;
  logic                   w_cs_fall;
  logic                   w_cs_rise;
  logic                   w_start;
  logic                   w_stop;
  logic                   w_sample;
  logic                   w_shift;
  logic                   w_boundary;
  logic                   w_load;
  logic [WIDTH-1:0]       w_shift_in_nxt;
  logic [WIDTH-1:0]       w_shift_out_adv;

  // Synchronise the asynchronous SPI pins and keep one history sample for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= {SYNC_STAGES{c_cpol}};
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_mosi_sync <= '0;
      r_fill      <= '0;
      r_sclk_d    <= c_cpol;
      r_cs_n_d    <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk_s;
      r_cs_n_d    <= w_cs_n_s;
    end
  end

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n_s  = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  // The synchroniser reset values are not real pin levels; wait until the
  // pipeline holds genuine samples before cs_n=1 may arm the slave.
  assign w_sync_ok = r_fill[SYNC_STAGES-1];

  assign w_lead        = (w_sclk_s != c_cpol) && (r_sclk_d == c_cpol);
  assign w_trail       = (w_sclk_s == c_cpol) && (r_sclk_d != c_cpol);
  assign w_sample_edge = (CPHA != 0) ? w_trail : w_lead;
  assign w_shift_edge  = (CPHA != 0) ? w_lead  : w_trail;
  assign w_cs_fall     = r_cs_n_d & ~w_cs_n_s;
  assign w_cs_rise     = ~r_cs_n_d & w_cs_n_s;

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and per-cycle frame events; sclk edges coinciding with cs_n rise are ignored
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = 1'b0;
    w_sample    = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && w_cs_fall) begin
          w_start     = 1'b1;
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          w_stop      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_sample = w_sample_edge;
          w_shift  = w_shift_edge;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_boundary      = w_sample && (r_bit_cnt == c_last);
  assign w_load          = w_start | w_boundary;
  assign w_shift_in_nxt  = (LSB_FIRST != 0) ? {w_mosi_s, r_shift_in[WIDTH-1:1]}
                                            : {r_shift_in[WIDTH-2:0], w_mosi_s};
  assign w_shift_out_adv = (LSB_FIRST != 0) ? {1'b0, r_shift_out[WIDTH-1:1]}
                                            : {r_shift_out[WIDTH-2:0], 1'b0};

  // Bit counting, shift registers, RX holding register and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed     <= 1'b0;
      r_bit_cnt   <= '0;
      r_sampled   <= 1'b0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_sync_ok && w_cs_n_s) r_armed <= 1'b1;

      r_underrun  <= w_load & ~bus.tx_valid;
      r_overrun   <= w_boundary & r_rx_valid & ~bus.rx_ready;
      r_frame_err <= w_stop & (r_bit_cnt != '0);

      if (w_start || w_stop) begin
        r_bit_cnt <= '0;
        r_sampled <= 1'b0;
      end else if (w_sample) begin
        r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + c_cnt_w'(1);
        r_sampled <= ~w_boundary;
      end else if (w_shift) begin
        r_sampled <= 1'b0;
      end

      // A bit is only shifted away after it has been sampled
      if (w_load)                    r_shift_out <= bus.tx_valid ? bus.tx_data : '0;
      else if (w_stop)               r_shift_out <= '0;
      else if (w_shift && r_sampled) r_shift_out <= w_shift_out_adv;

      if (w_start || w_stop) r_shift_in <= '0;
      else if (w_sample)     r_shift_in <= w_shift_in_nxt;

      if (w_boundary) begin
        r_rx_data  <= w_shift_in_nxt;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign bus.busy      = (r_state == ST_ACTIVE);
  assign bus.miso_oe   = (r_state == ST_ACTIVE);
  assign bus.miso      = (r_state == ST_ACTIVE) &&
                         ((LSB_FIRST != 0) ? r_shift_out[0] : r_shift_out[WIDTH-1]);
  assign bus.tx_ready  = w_load & bus.tx_valid;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.overrun   = r_overrun;
  assign bus.underrun  = r_underrun;
  assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_os.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_os
// Description : Self-checking bench for spi_slave_os. Five instances cover
//               modes 0-3 (MSB-first) and mode 0 LSB-first; one is selected
//               at a time through its cs_n. Table-driven frames plus
//               hand-written overrun, underrun/frame-error and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_os;

  localparam int W  = 8;
  localparam int NI = 5;
  localparam int H  = 8;   // clk cycles per sclk half period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk_raw = 1'b0;
  logic       cs_n_raw = 1'b1;
  logic       mosi = 1'b0;
  logic       rx_ready = 1'b1;
  logic       tx_valid;
  logic [7:0] tx_data;
  int         sel = 0;

  logic       miso_a [NI];
  logic       oe_a   [NI];
  logic       txr_a  [NI];
  logic       rxv_a  [NI];
  logic       ovr_a  [NI];
  logic       und_a  [NI];
  logic       ferr_a [NI];
  logic       busy_a [NI];
  logic [7:0] rxd_a  [NI];

  int checks = 0;
  int errors = 0;
  int n_txr, n_und, n_ovr, n_ferr, n_rx;
  bit busy_seen;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] misoq[$];

  typedef struct packed {
    logic [2:0]      inst;
    logic [1:0]      nw;
    logic [2:0][7:0] mo;
    logic [2:0][7:0] tx;
    logic [2:0]      exp_rx;
    logic [2:0]      exp_txr;
    logic [2:0]      exp_und;
  } vec_t;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int   P_CPOL = (k < 4) ? (k / 2) : 0;
    localparam int   P_CPHA = (k < 4) ? (k % 2) : 0;
    localparam int   P_LSB  = (k == 4) ? 1 : 0;
    localparam logic P_POL  = (P_CPOL != 0);

    spi_slave_os_if #(.WIDTH(W)) u_if ();

    assign u_if.sclk     = sclk_raw ^ P_POL;
    assign u_if.cs_n     = (sel == k) ? cs_n_raw : 1'b1;
    assign u_if.mosi     = mosi;
    assign u_if.tx_data  = tx_data;
    assign u_if.tx_valid = tx_valid;
    assign u_if.rx_ready = rx_ready;
    assign miso_a[k]     = u_if.miso;
    assign oe_a[k]       = u_if.miso_oe;
    assign txr_a[k]      = u_if.tx_ready;
    assign rxv_a[k]      = u_if.rx_valid;
    assign rxd_a[k]      = u_if.rx_data;
    assign ovr_a[k]      = u_if.overrun;
    assign und_a[k]      = u_if.underrun;
    assign ferr_a[k]     = u_if.frame_err;
    assign busy_a[k]     = u_if.busy;

    spi_slave_os #(
      .WIDTH(W), .CPOL(P_CPOL), .CPHA(P_CPHA), .LSB_FIRST(P_LSB), .SYNC_STAGES(2)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_h();
    repeat (H) @(posedge clk);
    #1;
  endtask

  task automatic zero_counters();
    n_txr = 0; n_und = 0; n_ovr = 0; n_ferr = 0; n_rx = 0; busy_seen = 0;
  endtask

  function automatic vec_t mk(input int inst, input int nw,
                              input logic [7:0] m0, m1, m2, t0, t1, t2,
                              input int erx, etxr, eund);
    vec_t v;
    v.inst = 3'(inst); v.nw = 2'(nw);
    v.mo[0] = m0; v.mo[1] = m1; v.mo[2] = m2;
    v.tx[0] = t0; v.tx[1] = t1; v.tx[2] = t2;
    v.exp_rx = 3'(erx); v.exp_txr = 3'(etxr); v.exp_und = 3'(eund);
    return v;
  endfunction

  // TX source: presents the head of txq, updated just after each clk edge
  always @(posedge clk) begin
    #1;
    tx_valid = (txq.size() > 0);
    tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
  end

  // Monitor for the selected instance: handshakes, pulses, scoreboards
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_a[sel]) busy_seen = 1;
      if (txr_a[sel]) begin
        n_txr++;
        if (txq.size() == 0) check("tx_ready_without_word", 32'd1, 32'd0);
        else misoq.push_back(txq.pop_front());
      end
      if (und_a[sel]) begin
        n_und++;
        misoq.push_back(8'h00);
      end
      if (ovr_a[sel])  n_ovr++;
      if (ferr_a[sel]) n_ferr++;
      if (rxv_a[sel] && rx_ready) begin
        n_rx++;
        if (rxq.size() == 0) check("rx_unexpected_word", {24'd0, rxd_a[sel]}, 32'hFFFF_FFFF);
        else check("rx_data", rxd_a[sel], rxq.pop_front());
      end
    end
  end

  // SPI master: drives nbits, decodes miso and checks each complete word
  task automatic spi_frame(input int nbits, input logic [2:0][7:0] mo);
    logic [7:0] rw;
    bit lsb, cpha;
    int w, idx;
    lsb  = (sel == 4);
    cpha = (sel < 4) && (sel % 2 == 1);
    rw   = '0;
    @(posedge clk); #1;
    cs_n_raw = 1'b0;
    wait_h();
    for (int i = 0; i < nbits; i++) begin
      w   = i / 8;
      idx = lsb ? (i % 8) : (7 - (i % 8));
      if (!cpha) begin
        mosi = mo[w][idx];
        wait_h();
        sclk_raw = 1'b1;
        rw[idx] = miso_a[sel];
        wait_h();
        sclk_raw = 1'b0;
      end else begin
        sclk_raw = 1'b1;
        mosi = mo[w][idx];
        wait_h();
        sclk_raw = 1'b0;
        rw[idx] = miso_a[sel];
        wait_h();
      end
      if (i == 2) begin
        check("busy_in_frame", busy_a[sel], 1'b1);
        check("miso_oe_in_frame", oe_a[sel], 1'b1);
      end
      if (i % 8 == 7) begin
        if (misoq.size() == 0) check("miso_word_unexpected", rw, 32'hFFFF_FFFF);
        else check("miso_word", rw, misoq.pop_front());
      end
    end
    wait_h();
    cs_n_raw = 1'b1;
    mosi = 1'b0;
    repeat (3) wait_h();
  endtask

  task automatic check_idle();
    check("idle_miso", miso_a[sel], 1'b0);
    check("idle_oe_busy", {oe_a[sel], busy_a[sel]}, 2'b00);
  endtask

  vec_t vecs[6];

  initial begin
    logic [2:0][7:0] m;
    vecs[0] = mk(0, 1, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 1, 1, 1);
    vecs[1] = mk(0, 3, 8'h01, 8'h80, 8'hFF, 8'h01, 8'h80, 8'hFF, 3, 3, 1);
    vecs[2] = mk(1, 3, 8'h01, 8'h80, 8'hFF, 8'h01, 8'h80, 8'hFF, 3, 3, 1);
    vecs[3] = mk(2, 3, 8'h01, 8'h80, 8'hFF, 8'h01, 8'h80, 8'hFF, 3, 3, 1);
    vecs[4] = mk(3, 3, 8'h01, 8'h80, 8'hFF, 8'h01, 8'h80, 8'hFF, 3, 3, 1);
    vecs[5] = mk(4, 1, 8'h01, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 1, 1, 1);
    zero_counters();

    // Reset state of every instance
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++)
      check("reset_outputs",
            {rxd_a[k], miso_a[k], oe_a[k], busy_a[k], rxv_a[k], txr_a[k],
             ovr_a[k], und_a[k], ferr_a[k]}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Table-driven frames
    for (int t = 0; t < 6; t++) begin
      sel = int'(vecs[t].inst);
      for (int w = 0; w < int'(vecs[t].nw); w++) begin
        txq.push_back(vecs[t].tx[w]);
        rxq.push_back(vecs[t].mo[w]);
      end
      zero_counters();
      repeat (2) @(posedge clk);
      #1;
      check_idle();
      spi_frame(int'(vecs[t].nw) * 8, vecs[t].mo);
      check("rx_count", n_rx, vecs[t].exp_rx);
      check("tx_ready_count", n_txr, vecs[t].exp_txr);
      check("underrun_count", n_und, vecs[t].exp_und);
      check("overrun_frame_err", {n_ovr[15:0], n_ferr[15:0]}, 32'd0);
      check("dropped_tx_load", misoq.size(), 1);
      check("rx_queue_drained", rxq.size(), 0);
      check_idle();
      misoq.delete();
    end

    // Overrun: two words with rx_ready low, no TX data available
    sel = 0;
    rx_ready = 1'b0;
    zero_counters();
    m = '0; m[0] = 8'h11; m[1] = 8'h22;
    spi_frame(16, m);
    check("overrun_count", n_ovr, 1);
    check("overrun_underruns", n_und, 3);
    check("overrun_rx_valid_held", rxv_a[0], 1'b1);
    check("overrun_rx_data", rxd_a[0], 8'h22);
    rxq.push_back(8'h22);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("overrun_rx_count", n_rx, 1);
    check("overrun_rx_cleared", rxv_a[0], 1'b0);
    misoq.delete();

    // Underrun at frame start, cs_n raised after 5 bits
    zero_counters();
    m = '0; m[0] = 8'hB7;
    spi_frame(5, m);
    check("partial_underrun", n_und, 1);
    check("partial_frame_err", n_ferr, 1);
    check("partial_no_rx", n_rx, 0);
    check("partial_no_overrun", n_ovr, 0);
    misoq.delete();

    // Reset asserted mid-word and released with cs_n still low
    sel = 0;
    @(posedge clk); #1;
    cs_n_raw = 1'b0;
    wait_h();
    for (int i = 0; i < 3; i++) begin
      mosi = i[0];
      wait_h(); sclk_raw = 1'b1;
      wait_h(); sclk_raw = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    zero_counters();
    for (int i = 0; i < 8; i++) begin
      mosi = ~mosi;
      wait_h(); sclk_raw = 1'b1;
      wait_h(); sclk_raw = 1'b0;
    end
    check("rst_mid_no_busy", busy_seen, 1'b0);
    check("rst_mid_no_rx", n_rx, 0);
    check("rst_mid_no_loads", n_txr + n_und, 0);
    cs_n_raw = 1'b1;
    mosi = 1'b0;
    repeat (3) wait_h();
    misoq.delete();
    txq.delete();
    zero_counters();
    txq.push_back(8'hC3);
    rxq.push_back(8'h5A);
    repeat (2) @(posedge clk);
    #1;
    m = '0; m[0] = 8'h5A;
    spi_frame(8, m);
    check("rst_after_rx_count", n_rx, 1);
    check("rst_after_tx_ready", n_txr, 1);
    check("rst_after_flags", {n_ovr[15:0], n_ferr[15:0]}, 32'd0);
    check_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
